lsu: RTL
========

# lsu

Load/store unit: the initiator for the core's byte-enabled data memory. Accepts one load or store request per handshake from the execute stage, checks alignment and funct3 legality, drives the memory port (four byte write-enables, byte address, write data), captures and sign/zero-extends load data, and returns a registered response with a valid/ready handshake. It sits between the datapath's memory stage and the data memory.

## Interface
- ADDRESS_WIDTH, 17, byte-address width of the data memory port
- DATA_WIDTH, 32, request/response data width (fixed at 32; other values unsupported)
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  unit can accept a request
- REQ_WE  in  1  1 = store, 0 = load
- REQ_FUNCT3  in  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- REQ_ADDR  in  32  byte address; only low ADDRESS_WIDTH bits used
- REQ_WDATA  in  32  store data (rs2)
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  consumer accepts response
- RSP_RDATA  out  32  extended load data; 0 for stores and errors
- RSP_ERR  out  1  misaligned address or illegal funct3; no memory access performed
- MEM_WE0..MEM_WE3  out  1 each  byte write-enables
- MEM_A  out  ADDRESS_WIDTH  byte address
- MEM_WD  out  32  write data
- MEM_RD  in  32  combinational read data

## Operation
- Memory port convention (fixed): MEM_WE0 writes MEM_WD[31:24] to byte A, WE1 writes MEM_WD[23:16] to A+1, WE2 MEM_WD[15:8] to A+2, WE3 MEM_WD[7:0] to A+3. MEM_RD = {A+3, A+2, A+1, A}, i.e. byte A in MEM_RD[7:0].
- FSM states IDLE, LOAD, STORE, RESP.
- IDLE: REQ_READY=1. On REQ_VALID&&REQ_READY capture we/funct3/addr/wdata. Error check: LH/LHU/SH with addr[0]!=0, LW/SW with addr[1:0]!=0, load funct3 in {011,110,111}, store funct3 not in {000,001,010}. Error -> RESP with RSP_ERR=1. Else load -> LOAD, store -> STORE.
- LOAD: MEM_A=captured addr; at cycle end register extended data: LB sext MEM_RD[7:0], LBU zext MEM_RD[7:0], LH sext MEM_RD[15:0], LHU zext MEM_RD[15:0], LW MEM_RD. -> RESP.
- STORE: one cycle of write-enables. SB: WE0, MEM_WD[31:24]=wdata[7:0]. SH: WE0/WE1, MEM_WD[31:24]=wdata[7:0], [23:16]=wdata[15:8]. SW: all four, MEM_WD={wdata[7:0],wdata[15:8],wdata[23:16],wdata[31:24]}. Unused MEM_WD bytes 0. -> RESP.
- RESP: RSP_VALID=1, RSP_RDATA/RSP_ERR stable until RSP_READY; on RSP_READY -> IDLE.
- MEM_WE* are 0 outside STORE; MEM_WD is 0 outside STORE; MEM_A always reflects the captured address register.

## Timing
- Reset (async assert): state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, MEM_WE*=0, MEM_A=0, MEM_WD=0, captured registers 0.
- Accept at edge N; LOAD/STORE occupies cycle N..N+1; RSP_VALID high from edge N+1 (N+2 counted from accept cycle start) for loads/stores; errors reach RESP at edge N (one cycle earlier).
- Store write commits at the edge ending the STORE cycle.
- REQ_READY=0 in LOAD, STORE, RESP; no request accepted in the same cycle a response is consumed. Peak throughput: one request per 3 cycles (2 for errors) with RSP_READY held high.
- RSP_READY low holds RESP indefinitely; outputs must not change.
- Reset asserted during STORE before the edge: write does not occur (WE drop asynchronously). Reset during RESP: response discarded.
- Address bits above ADDRESS_WIDTH ignored, not an error.

## Structure
- Package lsu_pkg: state enum (IDLE, LOAD, STORE, RESP), funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- One sub-module: lsu_load_ext, combinational funct3-driven sign/zero extension of MEM_RD.

## Test plan
- SW addr 0x100 wdata 0xDEADBEEF, then LW 0x100 -> MEM_WE0..3=1 with MEM_WD=0xEFBEADDE for one cycle; load RSP_RDATA=0xDEADBEEF, RSP_ERR=0.
- SB 0x203 wdata 0x000000F0, then LB 0x203 -> 0xFFFFFFF0; LBU 0x203 -> 0x000000F0; only MEM_WE0 asserted during store.
- SH 0x302 wdata 0x8001, LH 0x302 -> 0xFFFF8001; LHU 0x302 -> 0x00008001.
- LW 0x101, SH 0x303, load funct3 011 -> RSP_ERR=1, RSP_RDATA=0, no MEM_WE* pulse, response one cycle earlier than a legal access.
- Load completes with RSP_READY low for 5 cycles -> RSP_VALID/RSP_RDATA stable, REQ_READY=0 throughout; accept resumes the cycle after handshake.
- Assert RST_N=0 mid-STORE of SW 0x400 -> MEM_WE* drop immediately, later LW 0x400 returns pre-reset contents; all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when the request must be answered with an error and no memory access.
  function automatic logic req_illegal(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad_f3;
    logic misaligned;
    if (we) bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
    else    bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) ||
                 ((funct3 == F3_W) && (addr_lo != 2'b00));
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of the memory read word; byte A of the access sits in rd[7:0].
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rd,
  output logic [31:0] data
);

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{24{rd[7]}}, rd[7:0]};
      F3_BU:   data = {24'h0, rd[7:0]};
      F3_H:    data = {{16{rd[15]}}, rd[15:0]};
      F3_HU:   data = {16'h0, rd[15:0]};
      F3_W:    data = rd;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding request, byte-enabled memory initiator
// with a registered response.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_we0,
  output logic                     mem_we1,
  output logic                     mem_we2,
  output logic                     mem_we3,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd,
  output state_t                   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid and its payload hold until that edge, ready never waits on valid.

  state_t                   state;
  logic                     cap_we;
  logic [2:0]               cap_funct3;
  logic [ADDRESS_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0]    cap_wdata;
  logic [DATA_WIDTH-1:0]    ext_data;
  logic [3:0]               lanes;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDRESS_WIDTH];

  lsu_load_ext u_load_ext (
    .funct3 (cap_funct3),
    .rd     (mem_rd),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      cap_we     <= 1'b0;
      cap_funct3 <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cap_we     <= req_we;
            cap_funct3 <= req_funct3;
            cap_addr   <= req_addr[ADDRESS_WIDTH-1:0];
            cap_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (req_illegal(req_we, req_funct3, req_addr[1:0])) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we) begin
              state <= STORE;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          rsp_rdata <= ext_data;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        STORE: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write lanes follow the state register, so an async reset drops them at once.
  always_comb begin
    lanes  = 4'b0000;
    mem_wd = '0;
    if (state == STORE && cap_we) begin
      case (cap_funct3)
        F3_B: begin
          lanes         = 4'b0001;
          mem_wd[31:24] = cap_wdata[7:0];
        end
        F3_H: begin
          lanes         = 4'b0011;
          mem_wd[31:16] = {cap_wdata[7:0], cap_wdata[15:8]};
        end
        F3_W: begin
          lanes  = 4'b1111;
          mem_wd = {cap_wdata[7:0], cap_wdata[15:8], cap_wdata[23:16], cap_wdata[31:24]};
        end
        default: begin
          lanes  = 4'b0000;
          mem_wd = '0;
        end
      endcase
    end
  end

  assign mem_we0   = lanes[0];
  assign mem_we1   = lanes[1];
  assign mem_we2   = lanes[2];
  assign mem_we3   = lanes[3];
  assign mem_a     = cap_addr;
  assign dbg_state = state;

endmodule
